seq_multiplier: RTL and testbench

- Parametrised, iterative radix-2 shift-add multiplier: WIDTH x WIDTH operands, 2*WIDTH-bit product.
- Selectable unsigned or two's-complement signed mode.
- Successor to the team's fixed 4-bit combinational multiplier. Trades latency for area and adds a valid/ready handshake on both sides, so it can sit in a clocked datapath with backpressure.

---
 rtl/seq_multiplier.sv | 102 ++++++++++
 tb/tb_seq_multiplier.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier with valid/ready on both sides.
// Signed mode multiplies magnitudes and re-applies the sign at the end.
module seq_multiplier #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t               state_q, state_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_q, acc_d;       // upper half of the running product
    logic [WIDTH-1:0]     mplier_q, mplier_d; // lower half; multiplier bits shift out
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   mag;

    // -2^(W-1) negates to itself, which read as unsigned is the correct magnitude.
    assign a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    assign b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;

    // Carry out of the add is kept and shifted back into the accumulator.
    assign sum = {1'b0, acc_q} + {1'b0, mcand_q & {WIDTH{mplier_q[0]}}};
    assign mag = {sum, mplier_q[WIDTH-1:1]};

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign product   = prod_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end

    // Next-state: accept in IDLE, one shift-add step per CALC edge, drain in DONE
    always_comb begin
        state_d  = state_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    mcand_d  = a_mag;
                    mplier_d = b_mag;
                    acc_d    = '0;
                    cnt_d    = CNT_W'(WIDTH);
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = sum[WIDTH:1];
                mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    prod_d  = neg_q ? -mag : mag;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ordy = 1'b0;

    logic        iv4 = 1'b0, rdy4, sm4 = 1'b0, ov4;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  prod4;

    logic        iv8 = 1'b0, rdy8, sm8 = 1'b0, ov8;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] prod8;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4),
        .signed_mode(sm4), .a(a4), .b(b4), .out_valid(ov4),
        .out_ready(ordy), .product(prod4)
    );

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8),
        .signed_mode(sm8), .a(a8), .b(b8), .out_valid(ov8),
        .out_ready(ordy), .product(prod8)
    );

    // Reference: mathematical product of the operands interpreted per mode,
    // truncated to 2*w bits (two's complement for negative results).
    function automatic logic [15:0] model(input int w, input logic [7:0] av,
                                          input logic [7:0] bv, input logic s);
        int m, sa, sb;
        m  = (1 << w) - 1;
        sa = int'(av) & m;
        sb = int'(bv) & m;
        if (s && sa >= (1 << (w - 1))) sa -= (1 << w);
        if (s && sb >= (1 << (w - 1))) sb -= (1 << w);
        return 16'((sa * sb) & ((1 << (2 * w)) - 1));
    endfunction

    function automatic logic rdy(input bit w8);
        return w8 ? rdy8 : rdy4;
    endfunction

    function automatic logic ovl(input bit w8);
        return w8 ? ov8 : ov4;
    endfunction

    function automatic logic [15:0] prd(input bit w8);
        return w8 ? prod8 : {8'h00, prod4};
    endfunction

    task automatic drive(input bit w8, input logic v, input logic [7:0] av,
                         input logic [7:0] bv, input logic s);
        if (w8) begin
            iv8 = v; a8 = av; b8 = bv; sm8 = s;
        end else begin
            iv4 = v; a4 = av[3:0]; b4 = bv[3:0]; sm4 = s;
        end
    endtask

    // One full transaction; operands are scrambled every cycle after accept.
    // hold = cycles of out_ready=0 after out_valid rises.
    task automatic do_op(input bit w8, input logic [7:0] av, input logic [7:0] bv,
                         input logic s, input int hold);
        logic [15:0] exp, p0;
        int k, lat;
        lat = w8 ? 8 : 4;
        exp = model(lat, av, bv, s);
        ordy = (hold == 0);
        nvec++;
        if (rdy(w8) !== 1'b1) begin
            nerr++; $display("FAIL accept_ready: got %b want 1", rdy(w8));
        end
        drive(w8, 1'b1, av, bv, s);
        @(negedge clk);
        drive(w8, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        k = 0;
        while (ovl(w8) !== 1'b1 && k < 40) begin
            nvec++;
            if (rdy(w8) !== 1'b0) begin
                nerr++; $display("FAIL busy_ready: got %b want 0 at cycle %0d", rdy(w8), k);
            end
            drive(w8, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            @(negedge clk);
            k++;
        end
        nvec++;
        if (k != lat) begin
            nerr++; $display("FAIL latency: got %0d want %0d", k, lat);
        end
        nvec++;
        if (prd(w8) !== exp) begin
            nerr++; $display("FAIL product: a=%h b=%h s=%b got %h want %h", av, bv, s, prd(w8), exp);
        end
        p0 = prd(w8);
        for (int i = 0; i < hold; i++) begin
            drive(w8, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            @(negedge clk);
            nvec++;
            if (ovl(w8) !== 1'b1 || rdy(w8) !== 1'b0 || prd(w8) !== p0) begin
                nerr++;
                $display("FAIL hold: valid=%b ready=%b prod=%h want valid=1 ready=0 prod=%h",
                         ovl(w8), rdy(w8), prd(w8), p0);
            end
        end
        ordy = 1'b1;
        @(negedge clk);
        nvec++;
        if (ovl(w8) !== 1'b0 || rdy(w8) !== 1'b1 || prd(w8) !== exp) begin
            nerr++;
            $display("FAIL drain: valid=%b ready=%b prod=%h want valid=0 ready=1 prod=%h",
                     ovl(w8), rdy(w8), prd(w8), exp);
        end
    endtask

    task automatic test_reset;
        #1;
        nvec++;
        if (rdy4 !== 1'b1 || ov4 !== 1'b0 || prod4 !== 8'h00) begin
            nerr++; $display("FAIL reset4: ready=%b valid=%b prod=%h want 1 0 00", rdy4, ov4, prod4);
        end
        nvec++;
        if (rdy8 !== 1'b1 || ov8 !== 1'b0 || prod8 !== 16'h0000) begin
            nerr++; $display("FAIL reset8: ready=%b valid=%b prod=%h want 1 0 0000", rdy8, ov8, prod8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned;
        do_op(1'b0, 8'd2, 8'd3, 1'b0, 0);
        do_op(1'b0, 8'd12, 8'd10, 1'b0, 0);
        for (int i = 0; i < 8; i++) do_op(1'b0, 8'($urandom), 8'($urandom), 1'b0, 0);
    endtask

    task automatic test_signed;
        do_op(1'b0, 8'h0C, 8'h0A, 1'b1, 0);
        do_op(1'b0, 8'h08, 8'h07, 1'b1, 0);
        do_op(1'b0, 8'h08, 8'h08, 1'b1, 0);
        for (int i = 0; i < 8; i++) do_op(1'b0, 8'($urandom), 8'($urandom), 1'b1, 0);
    endtask

    task automatic test_width8;
        do_op(1'b1, 8'd255, 8'd255, 1'b0, 0);
        do_op(1'b1, 8'd0, 8'd200, 1'b0, 0);
        do_op(1'b1, 8'h80, 8'h80, 1'b1, 0);
        for (int i = 0; i < 8; i++) do_op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 0);
    endtask

    task automatic test_back_to_back;
        do_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 5);
        do_op(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 0);
        do_op(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 3);
    endtask

    task automatic test_reset_mid_calc;
        do_op(1'b0, 8'd7, 8'd9, 1'b0, 0);
        ordy = 1'b1;
        drive(1'b0, 1'b1, 8'd6, 8'd5, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        nvec++;
        if (ov4 !== 1'b0 || rdy4 !== 1'b1 || prod4 !== 8'h00) begin
            nerr++; $display("FAIL async_reset: valid=%b ready=%b prod=%h want 0 1 00", ov4, rdy4, prod4);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nvec++;
            if (ov4 !== 1'b0) begin
                nerr++; $display("FAIL reset_no_valid: got %b want 0", ov4);
            end
        end
        rst_n = 1'b1;
        do_op(1'b0, 8'd3, 8'd5, 1'b0, 0);
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_width8;
        test_back_to_back;
        test_reset_mid_calc;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
